// File: rtl/led_pwm_fader.sv
// LED PWM fader: each PIO bit sets a channel target (off / full on), and the channel
// brightness walks toward it in saturating steps, rendered as a shared-counter PWM duty.
module led_pwm_fader #(
    parameter int N_CH         = 8,
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 4,
    parameter int FADE_PERIODS = 2,
    parameter int STEP         = 16,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] in_port,
    input  logic            enable,
    output logic [N_CH-1:0] led_out,
    output logic            busy
);

    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FADE_W  = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;

    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [FADE_W-1:0]   FADE_LAST  = FADE_W'(FADE_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX    = '1;
    localparam logic [PWM_BITS:0]   LVL_MAX_W  = {1'b0, LVL_MAX};
    localparam logic [PWM_BITS:0]   STEP_W     = (PWM_BITS + 1)'(STEP);
    localparam logic [N_CH-1:0]     LED_OFF    = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [PRESC_W-1:0]               presc_q, presc_d;
    logic [PWM_BITS-1:0]              pwm_cnt_q, pwm_cnt_d;
    logic [FADE_W-1:0]                fade_cnt_q, fade_cnt_d;
    logic [N_CH-1:0][PWM_BITS-1:0]    level_q, level_d;
    logic [N_CH-1:0]                  in_reg_q;
    logic [N_CH-1:0]                  led_out_q, led_out_d;

    logic tick;
    logic period_end;
    logic fade_step;

    // NOTE: combinational blocks use blocking '=' and give every output a default
    // first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        tick       = (presc_q == PRESC_LAST);
        period_end = tick && (pwm_cnt_q == LVL_MAX);
        fade_step  = period_end && (fade_cnt_q == FADE_LAST);

        presc_d    = tick ? '0 : presc_q + PRESC_W'(1);
        pwm_cnt_d  = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        fade_cnt_d = fade_cnt_q;
        if (period_end) begin
            fade_cnt_d = fade_step ? '0 : fade_cnt_q + FADE_W'(1);
        end

        if (!enable) begin
            presc_d    = '0;
            pwm_cnt_d  = '0;
            fade_cnt_d = '0;
        end
    end

    // Step arithmetic is one bit wider than a level so saturation never wraps.
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS:0]   lvl_wide;
    logic [PWM_BITS:0]   sum_w;
    logic [PWM_BITS:0]   diff_w;
    logic [N_CH-1:0]     raw;

    always_comb begin
        level_d  = level_q;
        raw      = '0;
        busy     = 1'b0;
        target   = '0;
        lvl_wide = '0;
        sum_w    = '0;
        diff_w   = '0;
        for (int i = 0; i < N_CH; i++) begin
            target   = in_reg_q[i] ? LVL_MAX : '0;
            lvl_wide = {1'b0, level_q[i]};
            sum_w    = lvl_wide + STEP_W;
            diff_w   = lvl_wide - STEP_W;

            if (!enable) begin
                level_d[i] = '0;
            end else if (fade_step) begin
                if (level_q[i] < target) begin
                    level_d[i] = (sum_w > LVL_MAX_W) ? LVL_MAX : sum_w[PWM_BITS-1:0];
                end else if (level_q[i] > target) begin
                    level_d[i] = (lvl_wide < STEP_W) ? '0 : diff_w[PWM_BITS-1:0];
                end
            end

            raw[i] = (level_q[i] == LVL_MAX) || (pwm_cnt_q < level_q[i]);
            if (level_q[i] != target) begin
                busy = 1'b1;
            end
        end

        led_out_d = enable ? (raw ^ LED_OFF) : LED_OFF;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            fade_cnt_q <= '0;
            level_q    <= '0;
            in_reg_q   <= '0;
            led_out_q  <= LED_OFF;
        end else begin
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            fade_cnt_q <= fade_cnt_d;
            level_q    <= level_d;
            in_reg_q   <= in_port;
            led_out_q  <= led_out_d;
        end
    end

    assign led_out = led_out_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader: an active-high and an active-low instance share
// stimulus and are compared every cycle against a cycle-count based brightness model.
module tb_led_pwm_fader;

    localparam int N_CH      = 8;
    localparam int MAX       = 255;
    localparam int PRESCALE  = 4;
    localparam int STEP      = 16;
    localparam int FADE_CLKS = (MAX + 1) * PRESCALE * 2;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable  = 1'b0;
    logic [7:0] in_port = 8'h00;
    logic [7:0] led_out, led_out_al;
    logic       busy, busy_al;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    led_pwm_fader dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .enable  (enable),
        .led_out (led_out),
        .busy    (busy)
    );

    led_pwm_fader #(.ACTIVE_LOW(1)) dut_al (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .enable  (enable),
        .led_out (led_out_al),
        .busy    (busy_al)
    );

    // Reference model: brightness from the elapsed cycle count since the timebase started.
    int         m_t;
    int         m_level [N_CH];
    logic [7:0] m_in_reg;
    logic [7:0] m_led;
    logic       exp_busy;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_t      <= 0;
            m_in_reg <= '0;
            m_led    <= '0;
            for (int i = 0; i < N_CH; i++) m_level[i] <= 0;
        end else begin
            m_in_reg <= in_port;
            if (!enable) begin
                m_t   <= 0;
                m_led <= '0;
                for (int i = 0; i < N_CH; i++) m_level[i] <= 0;
            end else begin
                m_t <= m_t + 1;
                for (int i = 0; i < N_CH; i++) begin
                    m_led[i] <= (m_level[i] == MAX) || (((m_t / PRESCALE) % (MAX + 1)) < m_level[i]);
                    if ((m_t + 1) % FADE_CLKS == 0) begin
                        if (m_in_reg[i])
                            m_level[i] <= (m_level[i] + STEP > MAX) ? MAX : m_level[i] + STEP;
                        else
                            m_level[i] <= (m_level[i] - STEP < 0) ? 0 : m_level[i] - STEP;
                    end
                end
            end
        end
    end

    always_comb begin
        exp_busy = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (m_level[i] != (m_in_reg[i] ? MAX : 0)) exp_busy = 1'b1;
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        in_port = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({led_out, led_out_al, busy, busy_al} !== {8'h00, 8'hFF, 1'b0, 1'b0})
            $display("FAIL reset_state led=%h/%h busy=%b/%b required 00/ff 0/0", led_out, led_out_al, busy, busy_al);
        else n_pass++;
        reset_n = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            n_checks++;
            if ({led_out, led_out_al, busy, busy_al} !== {m_led, ~m_led, exp_busy, exp_busy})
                $display("FAIL idle_model t=%0t led=%h/%h busy=%b/%b required led=%h/%h busy=%b",
                         $time, led_out, led_out_al, busy, busy_al, m_led, ~m_led, exp_busy);
            else n_pass++;
        end
        n_checks++;
        if ({led_out, busy, dut.level_q} !== {8'h00, 1'b0, 64'h0})
            $display("FAIL idle_final led=%h busy=%b levels=%h required 00 0 0", led_out, busy, dut.level_q);
        else n_pass++;
    endtask

    task automatic test_reset_mid_ramp();
        bit found = 1'b0;
        in_port = 8'h01;
        for (int c = 0; c < 14000 && !found; c++) begin
            @(negedge clk);
            n_checks++;
            if ({led_out, led_out_al, busy, busy_al} !== {m_led, ~m_led, exp_busy, exp_busy})
                $display("FAIL midramp_model t=%0t led=%h/%h busy=%b/%b required led=%h/%h busy=%b",
                         $time, led_out, led_out_al, busy, busy_al, m_led, ~m_led, exp_busy);
            else n_pass++;
            if (dut.level_q[0] == 8'd96) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL midramp_reach level0=%0d required 96 within budget", dut.level_q[0]);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({led_out, led_out_al, busy, busy_al, dut.level_q} !== {8'h00, 8'hFF, 1'b0, 1'b0, 64'h0})
            $display("FAIL midramp_reset led=%h/%h busy=%b/%b levels=%h required 00/ff 0/0 0",
                     led_out, led_out_al, busy, busy_al, dut.level_q);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_ramp_and_duty();
        int k0 = 0, prev = 0, cur, exp_v, high = 0;
        logic [7:0] others = '0;
        for (int n = 1; n <= 24 * FADE_CLKS + 4; n++) begin
            @(negedge clk);
            n_checks++;
            if ({led_out, led_out_al, busy, busy_al} !== {m_led, ~m_led, exp_busy, exp_busy})
                $display("FAIL ramp_model t=%0t led=%h/%h busy=%b/%b required led=%h/%h busy=%b",
                         $time, led_out, led_out_al, busy, busy_al, m_led, ~m_led, exp_busy);
            else n_pass++;
            cur = int'(dut.level_q[0]);
            if (cur != prev) begin
                k0++;
                exp_v = (STEP * k0 > MAX) ? MAX : STEP * k0;
                n_checks++;
                if (cur !== exp_v || n !== FADE_CLKS * k0)
                    $display("FAIL ramp_step%0d level0=%0d at clk %0d required %0d at clk %0d",
                             k0, cur, n, exp_v, FADE_CLKS * k0);
                else n_pass++;
                prev = cur;
            end
            if (n >= 8 * FADE_CLKS + 2 && n < 8 * FADE_CLKS + 2 + 1024) begin
                high   += int'(led_out[0]);
                others |= {led_out[7:1], 1'b0};
            end
            if (n == 8 * FADE_CLKS + 2 + 1023) begin
                n_checks++;
                if (high !== 512 || others !== 8'h00)
                    $display("FAIL duty128 high=%0d others=%h required 512 00", high, others);
                else n_pass++;
            end
            if (n == 8 * FADE_CLKS + 2 + 1024) in_port = 8'hFF;
        end
        n_checks++;
        if (k0 !== 16) $display("FAIL ramp_count steps=%0d required 16", k0);
        else n_pass++;
        n_checks++;
        if ({dut.level_q, busy, led_out, led_out_al} !== {{8{8'hFF}}, 1'b0, 8'hFF, 8'h00})
            $display("FAIL full_on levels=%h busy=%b led=%h/%h required all ff 0 ff/00",
                     dut.level_q, busy, led_out, led_out_al);
        else n_pass++;
    endtask

    task automatic test_disable();
        enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({led_out, led_out_al, dut.level_q, dut_al.level_q} !== {8'h00, 8'hFF, 64'h0, 64'h0})
            $display("FAIL disable led=%h/%h levels=%h required 00/ff 0", led_out, led_out_al, dut.level_q);
        else n_pass++;
        n_checks++;
        if ({led_out, led_out_al, busy, busy_al} !== {m_led, ~m_led, exp_busy, exp_busy})
            $display("FAIL disable_model led=%h/%h busy=%b/%b required led=%h/%h busy=%b",
                     led_out, led_out_al, busy, busy_al, m_led, ~m_led, exp_busy);
        else n_pass++;
    endtask

    task automatic test_reverse();
        int exp_seq [4] = '{48, 32, 16, 0};
        int idx = 0, prev, cur;
        bit found = 1'b0;
        in_port = 8'h01;
        enable  = 1'b1;
        for (int c = 0; c < 9000 && !found; c++) begin
            @(negedge clk);
            n_checks++;
            if ({led_out, led_out_al, busy, busy_al} !== {m_led, ~m_led, exp_busy, exp_busy})
                $display("FAIL rev_up_model t=%0t led=%h/%h busy=%b/%b required led=%h/%h busy=%b",
                         $time, led_out, led_out_al, busy, busy_al, m_led, ~m_led, exp_busy);
            else n_pass++;
            if (dut.level_q[0] == 8'd64) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL rev_reach level0=%0d required 64 within budget", dut.level_q[0]);
        else n_pass++;
        in_port = 8'h00;
        prev = 64;
        for (int c = 0; c < 5 * FADE_CLKS && idx < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({led_out, led_out_al, busy, busy_al} !== {m_led, ~m_led, exp_busy, exp_busy})
                $display("FAIL rev_down_model t=%0t led=%h/%h busy=%b/%b required led=%h/%h busy=%b",
                         $time, led_out, led_out_al, busy, busy_al, m_led, ~m_led, exp_busy);
            else n_pass++;
            cur = int'(dut.level_q[0]);
            if (cur != prev) begin
                n_checks++;
                if (cur !== exp_seq[idx]) $display("FAIL rev_step%0d level0=%0d required %0d", idx, cur, exp_seq[idx]);
                else n_pass++;
                idx++;
                prev = cur;
            end
        end
        n_checks++;
        if (idx !== 4 || busy !== 1'b0)
            $display("FAIL rev_done steps=%0d busy=%b required 4 0", idx, busy);
        else n_pass++;
        repeat (500) @(negedge clk);
        n_checks++;
        if ({dut.level_q[0], busy, led_out[0]} !== {8'd0, 1'b0, 1'b0})
            $display("FAIL rev_hold level0=%0d busy=%b led0=%b required 0 0 0", dut.level_q[0], busy, led_out[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 8; seg++) begin
            in_port = 8'($urandom);
            enable  = ($urandom_range(0, 5) != 0);
            repeat ($urandom_range(100, 700)) begin
                @(negedge clk);
                n_checks++;
                if ({led_out, led_out_al, busy, busy_al} !== {m_led, ~m_led, exp_busy, exp_busy})
                    $display("FAIL random_model t=%0t led=%h/%h busy=%b/%b required led=%h/%h busy=%b",
                             $time, led_out, led_out_al, busy, busy_al, m_led, ~m_led, exp_busy);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_ramp();
        test_ramp_and_duty();
        test_disable();
        test_reverse();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
